// File: rtl/rf_pulse_tx.sv
// RF pulse transmitter: sends an all-ones preamble followed by a payload, MSB first,
// as one fixed-width pulse per '1' bit period on a single registered line.
module rf_pulse_tx #(
    parameter int PERIOD_CYC = 10000,
    parameter int PULSE_OFS  = 5000,
    parameter int HIGH_CYC   = 1,
    parameter int PRE_BITS   = 8,
    parameter int PKT_BITS   = 64,
    parameter int GAP_CYC    = 8
) (
    input  logic                i_PCLK,
    input  logic                i_PRESET,
    input  logic                i_START,
    input  logic [PKT_BITS-1:0] i_PKT,
    input  logic                i_ABORT,
    output logic                o_RFOUT,
    output logic                o_BUSY,
    output logic                o_DONE,
    output logic [6:0]          o_BIT_IDX,
    output logic [1:0]          o_STATE
);

    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W:0]   OFS_START = (CNT_W+1)'(PULSE_OFS);
    localparam logic [CNT_W:0]   OFS_END   = (CNT_W+1)'(PULSE_OFS + HIGH_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC);
    localparam logic [6:0]       LAST_PRE  = 7'(PRE_BITS - 1);
    localparam logic [6:0]       LAST_BIT  = 7'(PRE_BITS + PKT_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    if (HIGH_CYC < 1 || PULSE_OFS + HIGH_CYC > PERIOD_CYC) begin : g_bad_cfg
        $error("rf_pulse_tx: pulse does not fit inside the bit period");
    end

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [6:0]          idx_q, idx_d;
    logic [PKT_BITS-1:0] sr_q, sr_d;
    logic                rf_q, rf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic period_end;
    logic in_window;

    // cnt_q holds the cycle position inside the current bit period; the pulse is
    // registered, so rf_d asserted at position OFS appears on the line one edge later.
    assign period_end = (cnt_q == CNT_LAST);
    assign in_window  = ({1'b0, cnt_q} >= OFS_START) && ({1'b0, cnt_q} < OFS_END);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rf_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (i_START) begin
                    sr_d    = i_PKT;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    gap_d   = '0;
                    idx_d   = '0;
                    state_d = S_PRE;
                end
            end

            S_PRE: begin
                rf_d  = in_window;
                cnt_d = period_end ? '0 : cnt_q + CNT_W'(1);
                if (period_end) begin
                    idx_d = idx_q + 7'd1;
                    if (idx_q == LAST_PRE) begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                rf_d  = sr_q[PKT_BITS-1] && in_window;
                cnt_d = period_end ? '0 : cnt_q + CNT_W'(1);
                if (period_end) begin
                    sr_d = {sr_q[PKT_BITS-2:0], 1'b0};
                    // The index stays on the last bit for the whole gap.
                    if (idx_q == LAST_BIT) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort drops the frame without a completion strobe; a pulse in flight is cut.
        if (state_q != S_IDLE && i_ABORT) begin
            state_d = S_IDLE;
            rf_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
            gap_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            rf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            rf_q    <= rf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_RFOUT   = rf_q;
    assign o_BUSY    = busy_q;
    assign o_DONE    = done_q;
    assign o_BIT_IDX = idx_q;
    assign o_STATE   = state_q;

    a_done_single : assert property (@(posedge i_PCLK) disable iff (i_PRESET)
        o_DONE |=> !o_DONE);
    a_done_not_busy : assert property (@(posedge i_PCLK) disable iff (i_PRESET)
        !(o_DONE && o_BUSY));

endmodule

// File: doc/rf_pulse_tx.md
Name: rf_pulse_tx

Overview:
- Transmit-side counterpart of the RF pulse receiver behind `rfin` and `pkt_rec`.
- Serialises one 64-bit packet, preceded by an all-ones preamble, onto a single pulse line `o_RFOUT`.
- Line code per bit period: a '1' is one `HIGH_CYC`-wide pulse starting `PULSE_OFS` cycles into the period; a '0' is no pulse.
- Sits beside the APB interface; used as the on-chip loopback and stimulus source for the receiver.

Parameters:
- `PERIOD_CYC`, 10000, bit period in `i_PCLK` cycles (1 ms at 10 MHz).
- `PULSE_OFS`, 5000, pulse start offset within the period (50 % position).
- `HIGH_CYC`, 1, pulse width in cycles. Must be ≥1, and `PULSE_OFS+HIGH_CYC` must be ≤ `PERIOD_CYC`; other values are illegal configurations.
- `PRE_BITS`, 8, number of preamble '1' bits.
- `PKT_BITS`, 64, payload bits.
- `GAP_CYC`, 8, idle cycles after a frame before `o_DONE`.

Ports:
- `i_PCLK`  in  1  clock; all logic on rising edge.
- `i_PRESET`  in  1  synchronous, active-high reset.
- `i_START`  in  1  request to send; sampled only in IDLE.
- `i_PKT`  in  `PKT_BITS`  payload; captured on the accepted `i_START` edge; sent MSB first.
- `i_ABORT`  in  1  terminate the current frame.
- `o_RFOUT`  out  1  registered pulse line.
- `o_BUSY`  out  1  high from accept until `o_DONE`.
- `o_DONE`  out  1  one-cycle completion strobe.
- `o_BIT_IDX`  out  7  index of the bit currently in its period: 0..`PRE_BITS+PKT_BITS-1`.

Behaviour:
- Reset: on any edge with `i_PRESET`=1, the following apply next cycle regardless of state: state=IDLE, `o_RFOUT`=0, `o_BUSY`=0, `o_DONE`=0, `o_BIT_IDX`=0, counters=0, shift register=0. Reset overrides `i_START` and `i_ABORT`.
- States: IDLE → PRE → DATA → GAP → IDLE.
- IDLE: edge E0 with `i_START`=1 latches `i_PKT` into a shift register, sets `o_BUSY`=1 and goes to PRE.
  - `i_START` in any other state is ignored; it is neither queued nor counted.
- Bit timing:
  - Bit k (0-based, preamble first) occupies edges E0+1+k·`PERIOD_CYC` .. E0+(k+1)·`PERIOD_CYC`.
  - A period cycle counter `cnt` runs 0..`PERIOD_CYC-1` and wraps to 0 at each period boundary. Width is `$clog2(PERIOD_CYC)`.
  - If bit k = 1, `o_RFOUT` is 1 for exactly `HIGH_CYC` consecutive cycles, rising at edge E0+1+k·`PERIOD_CYC`+`PULSE_OFS`. Otherwise it stays 0.
- PRE: bits 0..`PRE_BITS-1` are all 1. On the wrap of the last preamble period, go to DATA.
- DATA: the transmitted bit is shift-register MSB. The register shifts left by 1 on each period wrap. After `PKT_BITS` periods, go to GAP.
- `o_BIT_IDX` increments on each period wrap and holds its last value in GAP.
- GAP:
  - Lasts `GAP_CYC` cycles with `o_RFOUT`=0 and `o_BUSY`=1.
  - At edge E0+(`PRE_BITS+PKT_BITS`)·`PERIOD_CYC`+`GAP_CYC`+1: `o_DONE`=1 for one cycle, `o_BUSY`=0, state=IDLE.
  - An `i_START` present in the `o_DONE` cycle is accepted (back-to-back frames).
- `i_ABORT`=1 in PRE, DATA or GAP:
  - Next edge: IDLE, `o_RFOUT`=0, `o_BUSY`=0, `cnt`=0, `o_BIT_IDX`=0. No `o_DONE` is issued.
  - In IDLE, `i_ABORT` is ignored.
  - `i_ABORT` and `i_START` together in IDLE: START wins.
- A pulse truncated by abort or reset is not completed.
- `o_RFOUT` is glitch-free: it is driven directly from a flop.

Test Plan:
- Bench overrides: `PERIOD_CYC`=20, `PULSE_OFS`=10, `HIGH_CYC`=2, `GAP_CYC`=8. Frame = 72·20 = 1440 cycles.
- Scenario 1 (reset values): hold `i_PRESET`=1 for 3 cycles with `i_START`=1 → `o_RFOUT`=`o_BUSY`=`o_DONE`=0 and `o_BIT_IDX`=0 throughout; no frame starts after release until a new `i_START`.
- Scenario 2 (mixed packet): `i_START` with `i_PKT`=64'h8123456789ABCD0F →
  - 38 pulses in total (8 preamble + 30 ones), each 2 cycles wide.
  - First rise 11 cycles after E0; bit-8 (payload MSB=1) rise at E0+171.
  - `o_DONE` at E0+1449.
  - A receiver model decodes 8123456789ABCD0F.
- Scenario 3 (all zeros): `i_PKT`=0 → exactly 8 pulses at E0+11+20k (k=0..7), none after; `o_DONE` at E0+1449.
- Scenario 4 (START while busy): `i_START` pulsed at E0+500 with `i_PKT`=all-ones → ignored; first frame content unchanged.
  - Then `i_START` held in the `o_DONE` cycle → a second frame begins, first rise 11 cycles after that edge.
- Scenario 5 (abort in DATA): `i_PKT`=all-ones, assert `i_ABORT` at E0+300 (bit 14, mid-pulse window if timed on a rise) → `o_RFOUT`=0 next edge, `o_BUSY`=0, no `o_DONE`; a new START restarts cleanly from the preamble.
- Scenario 6 (reset mid-frame): assert `i_PRESET` at E0+171 (pulse rising) → all outputs at reset values next edge; no `o_DONE` for the interrupted frame.
